// File: rtl/store_coalesce_buffer.sv
// rtl/store_coalesce_buffer.sv - FIFO-ordered store buffer with line coalescing and load forwarding
module store_coalesce_buffer #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 128,
    parameter int AFULL_LVL = 6
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   push_valid,
    output logic                                   push_ready,
    input  logic [ADDR_W-1:0]                      push_addr,
    input  logic [LINE_W-1:0]                      push_data,
    input  logic [LINE_W/8-1:0]                    push_be,
    output logic                                   drain_valid,
    input  logic                                   drain_ready,
    output logic [ADDR_W-$clog2(LINE_W/8)-1:0]     drain_addr,
    output logic [LINE_W-1:0]                      drain_data,
    output logic [LINE_W/8-1:0]                    drain_be,
    input  logic                                   lookup_valid,
    input  logic [ADDR_W-1:0]                      lookup_addr,
    output logic                                   lookup_hit,
    output logic [LINE_W-1:0]                      lookup_data,
    output logic [LINE_W/8-1:0]                    lookup_be,
    output logic [$clog2(DEPTH):0]                 count,
    output logic                                   empty,
    output logic                                   almost_full,
    output logic                                   full
);
    localparam int LINE_B = LINE_W / 8;
    localparam int OFF_W  = $clog2(LINE_B);
    localparam int LA_W   = ADDR_W - OFF_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [LA_W-1:0]   addr_q [DEPTH];
    logic [LA_W-1:0]   addr_d [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [LINE_W-1:0] data_d [DEPTH];
    logic [LINE_B-1:0] be_q   [DEPTH];
    logic [LINE_B-1:0] be_d   [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [LA_W-1:0]   push_line, lookup_line;
    logic              coal_hit, push_fire, drain_fire;
    logic [PTR_W-1:0]  match_idx, lk_idx;
    logic              unused_ok;

    assign push_line   = push_addr[ADDR_W-1:OFF_W];
    assign lookup_line = lookup_addr[ADDR_W-1:OFF_W];
    assign unused_ok   = ^{push_addr[OFF_W-1:0], lookup_addr[OFF_W-1:0]};

    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign almost_full = (count_q >= CNT_W'(AFULL_LVL));
    assign drain_valid = !empty;
    assign drain_addr  = addr_q[head_q];
    assign drain_data  = data_q[head_q];
    assign drain_be    = be_q[head_q];
    assign push_ready  = !full || coal_hit;
    assign push_fire   = push_valid && push_ready && (push_be != '0);
    assign drain_fire  = drain_valid && drain_ready;

    // The head may already be on its way to the cache, so it is excluded from coalescing.
    always_comb begin
        coal_hit  = 1'b0;
        match_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (PTR_W'(i) != head_q) && (addr_q[i] == push_line)) begin
                coal_hit  = 1'b1;
                match_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_fire) begin
            if (coal_hit) begin
                for (int b = 0; b < LINE_B; b++) begin
                    if (push_be[b]) begin
                        data_d[match_idx][8*b +: 8] = push_data[8*b +: 8];
                    end
                end
                be_d[match_idx] = be_q[match_idx] | push_be;
            end else begin
                valid_d[tail_q] = 1'b1;
                addr_d[tail_q]  = push_line;
                be_d[tail_q]    = push_be;
                for (int b = 0; b < LINE_B; b++) begin
                    data_d[tail_q][8*b +: 8] = push_be[b] ? push_data[8*b +: 8] : 8'h00;
                end
                tail_d  = tail_q + PTR_W'(1);
                count_d = count_d + CNT_W'(1);
            end
        end
        if (drain_fire) begin
            valid_d[head_q] = 1'b0;
            head_d  = head_q + PTR_W'(1);
            count_d = count_d - CNT_W'(1);
        end
    end

    // Walk oldest to youngest so a younger entry's bytes override the head's.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_be   = '0;
        lookup_data = '0;
        lk_idx      = '0;
        if (lookup_valid) begin
            for (int k = 0; k < DEPTH; k++) begin
                lk_idx = head_q + PTR_W'(k);
                if (valid_q[lk_idx] && (addr_q[lk_idx] == lookup_line)) begin
                    lookup_hit = 1'b1;
                    lookup_be  = lookup_be | be_q[lk_idx];
                    for (int b = 0; b < LINE_B; b++) begin
                        if (be_q[lk_idx][b]) begin
                            lookup_data[8*b +: 8] = data_q[lk_idx][8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        addr_q <= addr_d;
        data_q <= data_d;
        be_q   <= be_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (count_q <= CNT_W'(DEPTH));
        end
    end
endmodule

// File: tb/tb_store_coalesce_buffer.sv
// tb/tb_store_coalesce_buffer.sv - Directed and random checks of store_coalesce_buffer against a queue model
module tb_store_coalesce_buffer;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int LINE_B = 16;
    localparam int OFF_W  = 4;
    localparam int LA_W   = ADDR_W - OFF_W;
    localparam int AFULL  = 6;

    logic              clock = 1'b0;
    logic              reset;
    logic              push_valid, push_ready;
    logic [ADDR_W-1:0] push_addr;
    logic [LINE_W-1:0] push_data;
    logic [LINE_B-1:0] push_be;
    logic              drain_valid, drain_ready;
    logic [LA_W-1:0]   drain_addr;
    logic [LINE_W-1:0] drain_data;
    logic [LINE_B-1:0] drain_be;
    logic              lookup_valid, lookup_hit;
    logic [ADDR_W-1:0] lookup_addr;
    logic [LINE_W-1:0] lookup_data;
    logic [LINE_B-1:0] lookup_be;
    logic [3:0]        count;
    logic              empty, almost_full, full;

    always #5 clock = ~clock;

    store_coalesce_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .AFULL_LVL(AFULL)) dut (
        .clock(clock), .reset(reset),
        .push_valid(push_valid), .push_ready(push_ready), .push_addr(push_addr),
        .push_data(push_data), .push_be(push_be),
        .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_addr(drain_addr),
        .drain_data(drain_data), .drain_be(drain_be),
        .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
        .lookup_data(lookup_data), .lookup_be(lookup_be),
        .count(count), .empty(empty), .almost_full(almost_full), .full(full)
    );

    typedef struct {
        logic [LA_W-1:0]   line;
        logic [LINE_W-1:0] data;
        logic [LINE_B-1:0] be;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] expand(input logic [LINE_B-1:0] be);
        logic [LINE_W-1:0] r;
        for (int b = 0; b < LINE_B; b++) r[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
        return r;
    endfunction

    function automatic int find_coal(input logic [LA_W-1:0] line);
        for (int i = 1; i < q.size(); i++) if (q[i].line == line) return i;
        return -1;
    endfunction

    // Check every output against the model, then advance one clock and update the model.
    task automatic cycle(input string tag);
        logic [LA_W-1:0]   pl;
        int                j;
        bit                exp_ready, pf, df, eh;
        logic [LINE_W-1:0] ed, m;
        logic [LINE_B-1:0] eb;
        ent_t              e;
        #1;
        pl        = push_addr[ADDR_W-1:OFF_W];
        j         = find_coal(pl);
        exp_ready = (q.size() < DEPTH) || (j >= 0);
        chk({tag, ".push_ready"}, 128'(push_ready), 128'(exp_ready));
        chk({tag, ".count"}, 128'(count), 128'(q.size()));
        chk({tag, ".empty"}, 128'(empty), 128'(q.size() == 0));
        chk({tag, ".full"}, 128'(full), 128'(q.size() == DEPTH));
        chk({tag, ".almost_full"}, 128'(almost_full), 128'(q.size() >= AFULL));
        chk({tag, ".drain_valid"}, 128'(drain_valid), 128'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, ".drain_addr"}, 128'(drain_addr), 128'(q[0].line));
            chk({tag, ".drain_be"}, 128'(drain_be), 128'(q[0].be));
            chk({tag, ".drain_data"}, drain_data & expand(q[0].be), q[0].data);
        end
        eh = 1'b0; eb = '0; ed = '0;
        if (lookup_valid) begin
            foreach (q[i]) begin
                if (q[i].line == lookup_addr[ADDR_W-1:OFF_W]) begin
                    eh = 1'b1;
                    eb = eb | q[i].be;
                    m  = expand(q[i].be);
                    ed = (ed & ~m) | (q[i].data & m);
                end
            end
        end
        chk({tag, ".lookup_hit"}, 128'(lookup_hit), 128'(eh));
        chk({tag, ".lookup_be"}, 128'(lookup_be), 128'(eb));
        chk({tag, ".lookup_data"}, lookup_data, ed);
        pf = push_valid && exp_ready && (push_be != '0) && !reset;
        df = (q.size() != 0) && drain_ready && !reset;
        @(posedge clock);
        if (reset) begin
            q.delete();
        end else begin
            if (pf) begin
                m = expand(push_be);
                if (j >= 0) begin
                    e      = q[j];
                    e.data = (e.data & ~m) | (push_data & m);
                    e.be   = e.be | push_be;
                    q[j]   = e;
                end else begin
                    e.line = pl;
                    e.data = push_data & m;
                    e.be   = push_be;
                    q.push_back(e);
                end
            end
            if (df) void'(q.pop_front());
        end
        @(negedge clock);
    endtask

    task automatic drive_push(input logic [ADDR_W-1:0] a, input logic [LINE_B-1:0] be,
                              input logic [LINE_W-1:0] d);
        push_valid = 1'b1; push_addr = a; push_be = be; push_data = d;
    endtask

    task automatic do_reset();
        push_valid = 1'b0; drain_ready = 1'b0; lookup_valid = 1'b0;
        reset = 1'b1;
        cycle("rst");
        reset = 1'b0;
    endtask

    logic [LINE_W-1:0] d1, d3, d4;

    initial begin
        reset = 1'b1; push_valid = 1'b0; push_addr = '0; push_data = '0; push_be = '0;
        drain_ready = 1'b0; lookup_valid = 1'b0; lookup_addr = '0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        q.delete();

        // Reset state and first push
        lookup_valid = 1'b1; lookup_addr = 32'h100;
        #1;
        chk("t1.reset_empty", 128'(empty), 128'(1));
        chk("t1.reset_push_ready", 128'(push_ready), 128'(1));
        chk("t1.reset_hit", 128'(lookup_hit), 128'(0));
        lookup_valid = 1'b0;
        drive_push(32'h100, 16'h000F, 128'h11223344_55667788_99AABBCC_AABBCCDD);
        cycle("t1");
        push_valid = 1'b0;
        #1;
        chk("t1.drain_valid", 128'(drain_valid), 128'(1));
        chk("t1.count", 128'(count), 128'(1));
        chk("t1.drain_addr", 128'(drain_addr), 128'h10);
        chk("t1.drain_be", 128'(drain_be), 128'h000F);
        chk("t1.drain_lo", 128'(drain_data[31:0]), 128'hAABBCCDD);

        // Head not coalesced; later store coalesces into entry 2
        do_reset();
        d1 = {$urandom, $urandom, $urandom, $urandom};
        d3 = {$urandom, $urandom, $urandom, $urandom};
        d4 = {$urandom, $urandom, $urandom, $urandom};
        drive_push(32'h100, 16'h000F, d1);                   cycle("t2.a");
        drive_push(32'h200, 16'hFFFF, 128'h5);               cycle("t2.b");
        drive_push(32'h100, 16'h00F0, d3);                   cycle("t2.c");
        push_valid = 1'b0;
        #1 chk("t2.count3", 128'(count), 128'(3));
        drive_push(32'h100, 16'h0F00, d4);                   cycle("t2.d");
        push_valid = 1'b0;
        #1 chk("t2.count_stays3", 128'(count), 128'(3));
        lookup_valid = 1'b1; lookup_addr = 32'h104;
        #1;
        chk("t4.hit", 128'(lookup_hit), 128'(1));
        chk("t4.be", 128'(lookup_be), 128'h0FFF);
        chk("t4.bytes0_3", 128'(lookup_data[31:0]), 128'(d1[31:0]));
        chk("t4.bytes4_7", 128'(lookup_data[63:32]), 128'(d3[63:32]));
        chk("t4.bytes8_11", 128'(lookup_data[95:64]), 128'(d4[95:64]));
        chk("t4.bytes12_15", 128'(lookup_data[127:96]), 128'(0));
        cycle("t4");
        lookup_valid = 1'b0; drain_ready = 1'b1;
        cycle("t2.dr0");
        cycle("t2.dr1");
        #1 chk("t2.entry2_be", 128'(drain_be), 128'h0FF0);
        cycle("t2.dr2");

        // Fill to full, then full-with-drain push is rejected
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            drive_push(32'h1000 + 32'(k) * 32'h100, 16'(($urandom % 16'hFFFF) + 1),
                       {$urandom, $urandom, $urandom, $urandom});
            cycle("t3.fill");
        end
        push_valid = 1'b0; push_addr = 32'h5000;
        #1;
        chk("t3.full", 128'(full), 128'(1));
        chk("t3.almost_full", 128'(almost_full), 128'(1));
        chk("t3.ready_new", 128'(push_ready), 128'(0));
        push_addr = 32'h1100;
        #1 chk("t3.ready_2nd", 128'(push_ready), 128'(1));
        drive_push(32'h5000, 16'hFFFF, 128'h77);
        drain_ready = 1'b1;
        cycle("t3.reject");
        push_valid = 1'b0; drain_ready = 1'b0;
        #1 chk("t3.count7", 128'(count), 128'(7));

        // Drain with toggling ready, then wrap
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            drive_push(32'h3000 + 32'(k) * 32'h10, 16'hFFFF, {4{$urandom}});
            cycle("t5.fill");
        end
        push_valid = 1'b0;
        for (int c = 0; c < 2 * DEPTH + 2; c++) begin
            drain_ready = c[0];
            cycle("t5.drain");
        end
        #1 chk("t5.empty", 128'(empty), 128'(1));
        for (int k = 0; k < 4; k++) begin
            drive_push(32'h4000 + 32'(k) * 32'h10, 16'h00FF, {4{$urandom}});
            drain_ready = k[0];
            cycle("t5.wrap");
        end
        push_valid = 1'b0;

        // Reset mid-operation
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive_push(32'h6000 + 32'(k) * 32'h10, 16'h0F0F, {4{$urandom}});
            cycle("t6.fill");
        end
        #1 chk("t6.drain_valid", 128'(drain_valid), 128'(1));
        drive_push(32'h7000, 16'hFFFF, 128'h9);
        drain_ready = 1'b1; reset = 1'b1;
        cycle("t6.rst");
        reset = 1'b0; push_valid = 1'b0; drain_ready = 1'b0;
        lookup_valid = 1'b1; lookup_addr = 32'h6000;
        #1;
        chk("t6.count", 128'(count), 128'(0));
        chk("t6.empty", 128'(empty), 128'(1));
        chk("t6.hit", 128'(lookup_hit), 128'(0));
        cycle("t6.after");

        // Random traffic over a small set of lines to force coalescing and full conditions
        for (int n = 0; n < 2000; n++) begin
            push_valid   = ($urandom % 4) != 0;
            push_addr    = 32'h100 + 32'($urandom_range(0, 9)) * 32'h10 + 32'($urandom_range(0, 15));
            push_be      = (($urandom % 8) == 0) ? 16'h0 : 16'($urandom);
            push_data    = {$urandom, $urandom, $urandom, $urandom};
            drain_ready  = ($urandom % 3) == 0;
            lookup_valid = ($urandom % 2) == 0;
            lookup_addr  = 32'h100 + 32'($urandom_range(0, 9)) * 32'h10 + 32'($urandom_range(0, 15));
            reset        = ($urandom % 500) == 0;
            cycle("rnd");
        end
        reset = 1'b0; push_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
